// File: rtl/uart_pixel_writer.sv
// ---------------------------------------------------------------------------
// uart_pixel_writer
//
// Packs the UART byte stream into 24-bit pixels and writes them into port A
// of the frame BRAM in raster order. Every three accepted bytes (R, G, B)
// produce one write; the write pointer wraps at the end of the frame. An
// inter-byte idle timeout drops any partial pixel and realigns the stream
// to the start of the frame, so a sender that restarts after a gap always
// lands on pixel 0 with the phase at R.
//
// Ports
//   CLK100MHZ    in   system clock
//   rst          in   synchronous, active-high reset
//   rx_data      in   received byte
//   rx_valid     in   one-cycle strobe qualifying rx_data (may be back-to-back)
//   addrA        out  BRAM port-A address (current write pointer)
//   dina         out  BRAM port-A write data {R,G,B}, holds between writes
//   wea          out  BRAM port-A write enable, one pulse per pixel
//   frame_done   out  pulse together with the write of the last pixel
//   timeout_evt  out  pulse when a timeout discards a partial pixel/frame
//   byte_phase   out  0 = expect R, 1 = expect G, 2 = expect B
// ---------------------------------------------------------------------------
module uart_pixel_writer #(
   parameter int IMG_W       = 512,
   parameter int IMG_H       = 384,
   parameter int ADDR_W      = 18,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic              CLK100MHZ,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic [ADDR_W-1:0] addrA,
   output logic [23:0]       dina,
   output logic              wea,
   output logic              frame_done,
   output logic              timeout_evt,
   output logic [1:0]        byte_phase
);

   // Index of the last pixel; elaborated as a constant, so no multiplier
   // appears in the datapath.
   localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMG_W * IMG_H - 1);

   localparam int                IDLE_W   = $clog2(TIMEOUT_CYC);
   localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      PH_R = 2'd0,
      PH_G = 2'd1,
      PH_B = 2'd2
   } phase_t;

   phase_t            phase_q;
   logic [7:0]        r_q, g_q;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [IDLE_W-1:0] idle_q, idle_d;
   logic [23:0]       dina_q;
   logic              wea_q, frame_done_q, timeout_evt_q;
   logic              timeout_hit;

   // Next-state helpers for the pointer and the idle counter.
   // NOTE: every signal driven here gets a value on every path (the default
   // assignment first), otherwise synthesis infers a latch.
   always_comb begin
      ptr_d = ptr_q + ADDR_W'(1);
      if (ptr_q == LAST_PIX) ptr_d = '0;

      idle_d = idle_q;
      if (rx_valid)                idle_d = '0;
      else if (idle_q != IDLE_MAX) idle_d = idle_q + IDLE_W'(1);
   end

   // A byte arriving on the threshold cycle wins over the timeout.
   assign timeout_hit = !rx_valid && (idle_q == IDLE_MAX);

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of code order.
   always_ff @(posedge CLK100MHZ) begin
      if (rst) begin
         phase_q       <= PH_R;
         r_q           <= '0;
         g_q           <= '0;
         ptr_q         <= '0;
         idle_q        <= '0;
         dina_q        <= '0;
         wea_q         <= 1'b0;
         frame_done_q  <= 1'b0;
         timeout_evt_q <= 1'b0;
      end else begin
         wea_q         <= 1'b0;
         frame_done_q  <= 1'b0;
         timeout_evt_q <= 1'b0;
         idle_q        <= idle_d;

         // The pointer moves on the cycle after the write it addressed.
         if (wea_q) ptr_q <= ptr_d;

         if (rx_valid) begin
            case (phase_q)
               PH_R: begin
                  r_q     <= rx_data;
                  phase_q <= PH_G;
               end
               PH_G: begin
                  g_q     <= rx_data;
                  phase_q <= PH_B;
               end
               PH_B: begin
                  dina_q       <= {r_q, g_q, rx_data};
                  wea_q        <= 1'b1;
                  frame_done_q <= (ptr_q == LAST_PIX);
                  phase_q      <= PH_R;
               end
               default: phase_q <= PH_R;
            endcase
         end else if (timeout_hit) begin
            // Realign to frame start; only report it if something was lost.
            // The counter stays saturated, and once aligned this is silent.
            timeout_evt_q <= (phase_q != PH_R) || (ptr_q != '0);
            phase_q       <= PH_R;
            ptr_q         <= '0;
            r_q           <= '0;
            g_q           <= '0;
         end
      end
   end

   assign addrA       = ptr_q;
   assign dina        = dina_q;
   assign wea         = wea_q;
   assign frame_done  = frame_done_q;
   assign timeout_evt = timeout_evt_q;
   assign byte_phase  = phase_q;

endmodule

// File: tb/tb_uart_pixel_writer.sv
// ---------------------------------------------------------------------------
// tb_uart_pixel_writer
//
// Directed bench for uart_pixel_writer with a 4x2 frame and a 16-cycle idle
// timeout. Inputs change on the falling edge; a monitor samples outputs 1 ns
// after each rising edge to log writes and timeout pulses.
// ---------------------------------------------------------------------------
module tb_uart_pixel_writer;

   localparam int IMG_W       = 4;
   localparam int IMG_H       = 2;
   localparam int ADDR_W      = 3;
   localparam int TIMEOUT_CYC = 16;

   logic              CLK100MHZ = 1'b0;
   logic              rst       = 1'b0;
   logic [7:0]        rx_data   = 8'h00;
   logic              rx_valid  = 1'b0;
   logic [ADDR_W-1:0] addrA;
   logic [23:0]       dina;
   logic              wea;
   logic              frame_done;
   logic              timeout_evt;
   logic [1:0]        byte_phase;

   int n_checks = 0;
   int n_errors = 0;

   // Write log and timeout pulse counter filled by the monitor.
   int                wr_n   = 0;
   int                tevt_n = 0;
   logic [ADDR_W-1:0] wr_addr [16];
   logic [23:0]       wr_data [16];
   logic              wr_fd   [16];

   uart_pixel_writer #(
      .IMG_W      (IMG_W),
      .IMG_H      (IMG_H),
      .ADDR_W     (ADDR_W),
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .CLK100MHZ  (CLK100MHZ),
      .rst        (rst),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .addrA      (addrA),
      .dina       (dina),
      .wea        (wea),
      .frame_done (frame_done),
      .timeout_evt(timeout_evt),
      .byte_phase (byte_phase)
   );

   always #5 CLK100MHZ = ~CLK100MHZ;

   always @(posedge CLK100MHZ) begin
      #1;
      if (wea === 1'b1) begin
         if (wr_n < 16) begin
            wr_addr[wr_n] = addrA;
            wr_data[wr_n] = dina;
            wr_fd[wr_n]   = frame_done;
         end
         wr_n++;
      end
      if (timeout_evt === 1'b1) tevt_n++;
   end

   // ---------------------------------------------------------------- helpers
   task automatic send(input logic [7:0] b);
      @(negedge CLK100MHZ);
      rx_valid = 1'b1;
      rx_data  = b;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge CLK100MHZ);
         rx_valid = 1'b0;
      end
   endtask

   task automatic apply_reset();
      @(negedge CLK100MHZ);
      rst      = 1'b1;
      rx_valid = 1'b0;
      @(negedge CLK100MHZ);
      rst    = 1'b0;
      wr_n   = 0;
      tevt_n = 0;
   endtask

   // ------------------------------------------------------------------ tests
   task automatic test_reset();
      @(negedge CLK100MHZ);
      rst      = 1'b1;
      rx_valid = 1'b1;
      rx_data  = 8'hA5;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK100MHZ);
         if (i == 0) begin
            wr_n   = 0;
            tevt_n = 0;
         end
         n_checks++;
         if ({addrA, dina, wea, frame_done, timeout_evt, byte_phase} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs[%0d]: got addrA=%h dina=%h wea=%b fd=%b tevt=%b ph=%0d, want all 0",
                     i, addrA, dina, wea, frame_done, timeout_evt, byte_phase);
         end
         rx_valid = ~rx_valid;
         if (i == 2) begin
            rst      = 1'b0;
            rx_valid = 1'b0;
         end
      end
      @(negedge CLK100MHZ);
      n_checks++;
      if ({wea, byte_phase} !== 3'b000) begin
         n_errors++;
         $display("FAIL reset_after: got wea=%b ph=%0d, want wea=0 ph=0", wea, byte_phase);
      end
      n_checks++;
      if (wr_n !== 0) begin
         n_errors++;
         $display("FAIL reset_no_write: got %0d writes, want 0", wr_n);
      end
      // A timeout while already aligned must stay silent.
      idle(2 * TIMEOUT_CYC);
      n_checks++;
      if (tevt_n !== 0 || timeout_evt !== 1'b0) begin
         n_errors++;
         $display("FAIL silent_timeout: got %0d timeout pulses, want 0", tevt_n);
      end
   endtask

   task automatic test_single_pixel();
      apply_reset();
      send(8'h12);
      idle(1);
      n_checks++;
      if (byte_phase !== 2'd1) begin
         n_errors++;
         $display("FAIL sp_phase_g: got %0d want 1", byte_phase);
      end
      idle(2);
      send(8'h34);
      idle(1);
      n_checks++;
      if (byte_phase !== 2'd2 || wea !== 1'b0) begin
         n_errors++;
         $display("FAIL sp_phase_b: got ph=%0d wea=%b want ph=2 wea=0", byte_phase, wea);
      end
      idle(2);
      send(8'h56);
      idle(1);
      n_checks++;
      if ({wea, addrA, dina, frame_done} !== {1'b1, 3'd0, 24'h123456, 1'b0}) begin
         n_errors++;
         $display("FAIL sp_write: got wea=%b addrA=%0d dina=%h fd=%b want wea=1 addrA=0 dina=123456 fd=0",
                  wea, addrA, dina, frame_done);
      end
      idle(1);
      n_checks++;
      if ({wea, addrA, dina} !== {1'b0, 3'd1, 24'h123456}) begin
         n_errors++;
         $display("FAIL sp_after: got wea=%b addrA=%0d dina=%h want wea=0 addrA=1 dina=123456",
                  wea, addrA, dina);
      end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      for (int k = 0; k < 24; k++) send(8'(k));
      idle(1);
      n_checks++;
      if ({wea, addrA, dina, frame_done} !== {1'b1, 3'd7, 24'h151617, 1'b1}) begin
         n_errors++;
         $display("FAIL b2b_last: got wea=%b addrA=%0d dina=%h fd=%b want wea=1 addrA=7 dina=151617 fd=1",
                  wea, addrA, dina, frame_done);
      end
      idle(1);
      n_checks++;
      if ({wea, addrA, frame_done, byte_phase} !== {1'b0, 3'd0, 1'b0, 2'd0}) begin
         n_errors++;
         $display("FAIL b2b_wrap: got wea=%b addrA=%0d fd=%b ph=%0d want 0 0 0 0",
                  wea, addrA, frame_done, byte_phase);
      end
      n_checks++;
      if (wr_n !== 8) begin
         n_errors++;
         $display("FAIL b2b_count: got %0d writes want 8", wr_n);
      end
      for (int i = 0; i < 8 && i < wr_n; i++) begin
         n_checks++;
         if ({wr_addr[i], wr_data[i], wr_fd[i]} !==
             {3'(i), 8'(3 * i), 8'(3 * i + 1), 8'(3 * i + 2), (i == 7)}) begin
            n_errors++;
            $display("FAIL b2b_pix[%0d]: got addrA=%0d dina=%h fd=%b want addrA=%0d dina=%h fd=%b",
                     i, wr_addr[i], wr_data[i], wr_fd[i], i,
                     {8'(3 * i), 8'(3 * i + 1), 8'(3 * i + 2)}, (i == 7));
         end
      end
   endtask

   task automatic test_timeout_mid_pixel();
      apply_reset();
      for (int k = 0; k < 6; k++) send(8'(8'hC0 + k));
      idle(2);
      n_checks++;
      if (addrA !== 3'd2) begin
         n_errors++;
         $display("FAIL to_ptr: got addrA=%0d want 2", addrA);
      end
      tevt_n = 0;
      send(8'hAA);
      idle(1);
      n_checks++;
      if (byte_phase !== 2'd1) begin
         n_errors++;
         $display("FAIL to_phase: got %0d want 1", byte_phase);
      end
      // One cycle before the threshold takes effect: nothing yet.
      idle(TIMEOUT_CYC - 1);
      n_checks++;
      if ({timeout_evt, byte_phase, addrA} !== {1'b0, 2'd1, 3'd2}) begin
         n_errors++;
         $display("FAIL to_early: got tevt=%b ph=%0d addrA=%0d want tevt=0 ph=1 addrA=2",
                  timeout_evt, byte_phase, addrA);
      end
      idle(1);
      n_checks++;
      if ({timeout_evt, byte_phase, addrA} !== {1'b1, 2'd0, 3'd0}) begin
         n_errors++;
         $display("FAIL to_fire: got tevt=%b ph=%0d addrA=%0d want tevt=1 ph=0 addrA=0",
                  timeout_evt, byte_phase, addrA);
      end
      idle(10);
      n_checks++;
      if (tevt_n !== 1) begin
         n_errors++;
         $display("FAIL to_once: got %0d timeout pulses want 1", tevt_n);
      end
      wr_n = 0;
      send(8'h01);
      send(8'h02);
      send(8'h03);
      idle(1);
      n_checks++;
      if ({wea, addrA, dina} !== {1'b1, 3'd0, 24'h010203}) begin
         n_errors++;
         $display("FAIL to_resync: got wea=%b addrA=%0d dina=%h want wea=1 addrA=0 dina=010203",
                  wea, addrA, dina);
      end
   endtask

   task automatic test_race();
      apply_reset();
      send(8'h77);
      idle(TIMEOUT_CYC - 1);
      // This byte is sampled on the edge where the idle counter sits at 15.
      send(8'h88);
      idle(1);
      n_checks++;
      if ({timeout_evt, byte_phase} !== {1'b0, 2'd2}) begin
         n_errors++;
         $display("FAIL race_phase: got tevt=%b ph=%0d want tevt=0 ph=2", timeout_evt, byte_phase);
      end
      send(8'h99);
      idle(1);
      n_checks++;
      if ({wea, addrA, dina} !== {1'b1, 3'd0, 24'h778899}) begin
         n_errors++;
         $display("FAIL race_write: got wea=%b addrA=%0d dina=%h want wea=1 addrA=0 dina=778899",
                  wea, addrA, dina);
      end
      n_checks++;
      if (tevt_n !== 0) begin
         n_errors++;
         $display("FAIL race_tevt: got %0d timeout pulses want 0", tevt_n);
      end
   endtask

   task automatic test_reset_mid_frame();
      apply_reset();
      for (int k = 0; k < 18; k++) send(8'(8'h40 + k));
      idle(2);
      n_checks++;
      if (addrA !== 3'd6) begin
         n_errors++;
         $display("FAIL rmf_ptr: got addrA=%0d want 6", addrA);
      end
      send(8'h11);
      @(negedge CLK100MHZ);
      rx_valid = 1'b1;
      rx_data  = 8'h22;
      rst      = 1'b1;
      @(negedge CLK100MHZ);
      rst      = 1'b0;
      rx_valid = 1'b0;
      wr_n     = 0;
      n_checks++;
      if ({wea, addrA, byte_phase} !== {1'b0, 3'd0, 2'd0}) begin
         n_errors++;
         $display("FAIL rmf_cleared: got wea=%b addrA=%0d ph=%0d want 0 0 0", wea, addrA, byte_phase);
      end
      send(8'h33);
      send(8'h44);
      send(8'h55);
      idle(1);
      n_checks++;
      if ({wea, addrA, dina} !== {1'b1, 3'd0, 24'h334455}) begin
         n_errors++;
         $display("FAIL rmf_write: got wea=%b addrA=%0d dina=%h want wea=1 addrA=0 dina=334455",
                  wea, addrA, dina);
      end
      n_checks++;
      if (wr_n !== 1) begin
         n_errors++;
         $display("FAIL rmf_count: got %0d writes want 1", wr_n);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion within 200000 ns, want completion");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single_pixel();
      test_back_to_back();
      test_timeout_mid_pixel();
      test_race();
      test_reset_mid_frame();
      idle(2);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
